// File: rtl/ndf_pkg.sv
// rtl/ndf_pkg.sv - shared constants, FSM encoding and address helper for the NAND page reader
//
// Purpose: NAND command opcodes, the 4-bit page-read FSM state encoding and
//          the address-byte selector used when issuing address cycles.
// Ports:   none (package).

package ndf_pkg;

  localparam logic [7:0] NDF_CMD_READ1 = 8'h00;
  localparam logic [7:0] NDF_CMD_READ2 = 8'h30;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CMD1_S  = 4'd1,
    S_CMD1_H  = 4'd2,
    S_ADDR_S  = 4'd3,
    S_ADDR_H  = 4'd4,
    S_CMD2_S  = 4'd5,
    S_CMD2_H  = 4'd6,
    S_TWB     = 4'd7,
    S_WAIT_RB = 4'd8,
    S_RD_L1   = 4'd9,
    S_RD_L2   = 4'd10,
    S_RD_H    = 4'd11,
    S_DONE    = 4'd12,
    S_ERR     = 4'd13
  } ndf_state_e;

  // Address cycle idx: two column bytes first, then row bytes, each LSB first.
  function automatic logic [7:0] ndf_addr_byte(input logic [15:0] col,
                                               input logic [23:0] row,
                                               input logic [2:0]  idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = col[7:0];
      3'd1:    b = col[15:8];
      3'd2:    b = row[7:0];
      3'd3:    b = row[15:8];
      3'd4:    b = row[23:16];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ndf_rb_sync.sv
// rtl/ndf_rb_sync.sv - two-flop synchronizer for the NAND ready/busy line
//
// Purpose: brings the asynchronous open-drain R/B# into the clk10 domain.
//          Resets to 1 (ready) so the idle bus never looks busy.
// Ports:
//   clk_i    in  1  system clock
//   rst_i    in  1  synchronous active-high reset
//   rb_n_i   in  1  raw R/B# from the pin
//   rb_n_o   out 1  synchronized R/B#, two cycles of latency

module ndf_rb_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rb_n_i,
  output logic rb_n_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rb_n_i;
      sync_q <= meta_q;
    end
  end

  assign rb_n_o = sync_q;

endmodule

// File: rtl/ndf_page_reader.sv
// rtl/ndf_page_reader.sv - sequences one NAND page read and streams the bytes out
//
// Purpose: issues 00h, ADDR_CYCLES address bytes and 30h, waits for R/B# high
//          (with a timeout), then strobes RE# LEN times and presents each byte
//          on a valid/ready stream. All outputs are registered.
// Ports:
//   clk10, rst               clock (10 MHz) and synchronous active-high reset
//   start, col, row, len     request; inputs latched when start is accepted
//   busy, done, timeout      operation status (done/timeout are 1-cycle pulses)
//   ndf_r_b_n                asynchronous ready/busy from the flash
//   ndf_ce_n..ndf_wp_n       flash control strobes
//   ndf_io_o, ndf_io_oe      flash write data and its drive enable
//   ndf_io_i                 flash read data
//   dout_data/valid/ready    read byte stream

module ndf_page_reader
  import ndf_pkg::*;
#(
  parameter int ADDR_CYCLES    = 5,
  parameter int LEN_W          = 13,
  parameter int TWB_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic             clk10,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      col,
  input  logic [23:0]      row,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  input  logic             ndf_r_b_n,
  output logic             ndf_ce_n,
  output logic             ndf_cle,
  output logic             ndf_ale,
  output logic             ndf_we_n,
  output logic             ndf_re_n,
  output logic             ndf_wp_n,
  output logic [7:0]       ndf_io_o,
  output logic             ndf_io_oe,
  input  logic [7:0]       ndf_io_i,
  output logic [7:0]       dout_data,
  output logic             dout_valid,
  input  logic             dout_ready
);

  // One counter serves the address loop, tWB idle and the R/B# timeout.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TWB_LAST  = CNT_W'(TWB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  ndf_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] bcnt_q, bcnt_d;
  logic [15:0]      col_q, col_d;
  logic [23:0]      row_q, row_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       dout_data_q, dout_data_d;
  logic             dout_valid_q, dout_valid_d;

  logic             ce_n_q, ce_n_d;
  logic             cle_q, cle_d;
  logic             ale_q, ale_d;
  logic             we_n_q, we_n_d;
  logic             re_n_q, re_n_d;
  logic [7:0]       io_o_q, io_o_d;
  logic             io_oe_q, io_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             rb_n_sync;

  ndf_rb_sync u_rb_sync (
    .clk_i  (clk10),
    .rst_i  (rst),
    .rb_n_i (ndf_r_b_n),
    .rb_n_o (rb_n_sync)
  );

  always_ff @(posedge clk10) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      len_q        <= '0;
      dout_data_q  <= 8'h00;
      dout_valid_q <= 1'b0;
      ce_n_q       <= 1'b1;
      cle_q        <= 1'b0;
      ale_q        <= 1'b0;
      we_n_q       <= 1'b1;
      re_n_q       <= 1'b1;
      io_o_q       <= 8'h00;
      io_oe_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      len_q        <= len_d;
      dout_data_q  <= dout_data_d;
      dout_valid_q <= dout_valid_d;
      ce_n_q       <= ce_n_d;
      cle_q        <= cle_d;
      ale_q        <= ale_d;
      we_n_q       <= we_n_d;
      re_n_q       <= re_n_d;
      io_o_q       <= io_o_d;
      io_oe_q      <= io_oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bcnt_d       = bcnt_q;
    col_d        = col_q;
    row_d        = row_q;
    len_d        = len_q;
    dout_data_d  = dout_data_q;
    dout_valid_d = dout_valid_q;

    // Holding register drains on a handshake; a capture below overrides it.
    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_CMD1_S;
          col_d   = col;
          row_d   = row;
          len_d   = len;
          bcnt_d  = '0;
        end
      end
      S_CMD1_S: state_d = S_CMD1_H;
      S_CMD1_H: begin
        state_d = S_ADDR_S;
        cnt_d   = '0;
      end
      S_ADDR_S: state_d = S_ADDR_H;
      S_ADDR_H: begin
        if (cnt_q == ADDR_LAST) begin
          state_d = S_CMD2_S;
          cnt_d   = '0;
        end else begin
          state_d = S_ADDR_S;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_CMD2_S: state_d = S_CMD2_H;
      S_CMD2_H: begin
        state_d = S_TWB;
        cnt_d   = '0;
      end
      S_TWB: begin
        if (cnt_q == TWB_LAST) begin
          state_d = S_WAIT_RB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_RB: begin
        // Ready wins over an expiring timeout in the same cycle.
        if (rb_n_sync) begin
          state_d = (len_q == '0) ? S_DONE : S_RD_L1;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_L1: state_d = S_RD_L2;
      S_RD_L2: begin
        state_d      = S_RD_H;
        dout_data_d  = ndf_io_i;
        dout_valid_d = 1'b1;
        bcnt_d       = bcnt_q + 1'b1;
      end
      S_RD_H: begin
        // No new RE# pulse while a byte is still waiting for the consumer.
        if (!(dout_valid_q && !dout_ready)) begin
          state_d = (bcnt_q == len_q) ? S_DONE : S_RD_L1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pin
  // changes on the same edge the FSM enters the state that owns it.
  always_comb begin
    ce_n_d    = 1'b1;
    cle_d     = 1'b0;
    ale_d     = 1'b0;
    we_n_d    = 1'b1;
    re_n_d    = 1'b1;
    io_o_d    = 8'h00;
    io_oe_d   = 1'b0;
    busy_d    = (state_d != S_IDLE);
    done_d    = 1'b0;
    timeout_d = 1'b0;

    unique case (state_d)
      S_CMD1_S, S_CMD1_H: begin
        ce_n_d  = 1'b0;
        cle_d   = 1'b1;
        we_n_d  = (state_d != S_CMD1_S);
        io_oe_d = 1'b1;
        io_o_d  = NDF_CMD_READ1;
      end
      S_ADDR_S, S_ADDR_H: begin
        ce_n_d  = 1'b0;
        ale_d   = 1'b1;
        we_n_d  = (state_d != S_ADDR_S);
        io_oe_d = 1'b1;
        io_o_d  = ndf_addr_byte(col_d, row_d, cnt_d[2:0]);
      end
      S_CMD2_S, S_CMD2_H: begin
        ce_n_d  = 1'b0;
        cle_d   = 1'b1;
        we_n_d  = (state_d != S_CMD2_S);
        io_oe_d = 1'b1;
        io_o_d  = NDF_CMD_READ2;
      end
      S_TWB, S_WAIT_RB, S_RD_H: begin
        ce_n_d = 1'b0;
      end
      S_RD_L1, S_RD_L2: begin
        ce_n_d = 1'b0;
        re_n_d = 1'b0;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      S_ERR: begin
        timeout_d = 1'b1;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign ndf_ce_n   = ce_n_q;
  assign ndf_cle    = cle_q;
  assign ndf_ale    = ale_q;
  assign ndf_we_n   = we_n_q;
  assign ndf_re_n   = re_n_q;
  assign ndf_wp_n   = 1'b0;
  assign ndf_io_o   = io_o_q;
  assign ndf_io_oe  = io_oe_q;
  assign dout_data  = dout_data_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ndf_page_reader.sv
// tb/tb_ndf_page_reader.sv - self-checking bench for ndf_page_reader with a NAND and consumer model

module tb_ndf_page_reader;

  localparam int ADDR_CYCLES    = 5;
  localparam int LEN_W          = 13;
  localparam int TWB_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 20000;

  logic             clk10 = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      col = '0;
  logic [23:0]      row = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, timeout;
  logic             ndf_r_b_n = 1'b1;
  logic             ndf_ce_n, ndf_cle, ndf_ale, ndf_we_n, ndf_re_n, ndf_wp_n;
  logic [7:0]       ndf_io_o;
  logic             ndf_io_oe;
  logic [7:0]       ndf_io_i = 8'h00;
  logic [7:0]       dout_data;
  logic             dout_valid;
  logic             dout_ready = 1'b1;

  ndf_page_reader #(
    .ADDR_CYCLES    (ADDR_CYCLES),
    .LEN_W          (LEN_W),
    .TWB_CYCLES     (TWB_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk10      (clk10),
    .rst        (rst),
    .start      (start),
    .col        (col),
    .row        (row),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .ndf_r_b_n  (ndf_r_b_n),
    .ndf_ce_n   (ndf_ce_n),
    .ndf_cle    (ndf_cle),
    .ndf_ale    (ndf_ale),
    .ndf_we_n   (ndf_we_n),
    .ndf_re_n   (ndf_re_n),
    .ndf_wp_n   (ndf_wp_n),
    .ndf_io_o   (ndf_io_o),
    .ndf_io_oe  (ndf_io_oe),
    .ndf_io_i   (ndf_io_i),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #50 clk10 = ~clk10;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model configuration, written by the stimulus process only.
  int         cfg_rb_cycles = 10;
  bit         cfg_rb_forever = 1'b0;
  int         cfg_mode = 0;
  logic [7:0] mdata [4096];

  // Observations, written by the monitor only.
  int         cyc = 0;
  int         wr_q[$];
  logic [7:0] rx_q[$];
  int re_pulses = 0, rd_idx = 0, valid_cycles = 0, done_cnt = 0, to_cnt = 0;
  int done_cyc = -1, to_cyc = -1, c2_cyc = -1, rise_cyc = -1;
  int we_viol = 0, hold_viol = 0, first_valid_cyc = -1, re_at_ready = -1, rb_cnt = 0;
  logic p_busy = 1'b0, p_we_n = 1'b1, p_re_n = 1'b1, p_cle = 1'b0, p_ale = 1'b0, p_ready = 1'b1;
  logic [7:0] p_io = 8'h00;

  always @(posedge clk10) cyc <= cyc + 1;

  // NAND flash + stream consumer model, evaluated mid-cycle.
  always @(negedge clk10) begin
    if (busy && !p_busy) begin
      wr_q.delete();
      rx_q.delete();
      re_pulses = 0; rd_idx = 0; valid_cycles = 0; done_cnt = 0; to_cnt = 0;
      done_cyc = -1; to_cyc = -1; c2_cyc = -1; rise_cyc = -1;
      we_viol = 0; hold_viol = 0; first_valid_cyc = -1; re_at_ready = -1;
      ndf_r_b_n = 1'b1;
    end
    if (!ndf_we_n) begin
      wr_q.push_back(int'({ndf_cle, ndf_ale, ndf_io_o}));
      if (!p_we_n) we_viol++;
      if (!ndf_io_oe) hold_viol++;
      if (ndf_cle && ndf_io_o == 8'h30) begin
        c2_cyc    = cyc;
        ndf_r_b_n = 1'b0;
        rb_cnt    = cfg_rb_cycles;
      end
    end else if (!p_we_n) begin
      if (ndf_io_o != p_io || ndf_cle != p_cle || ndf_ale != p_ale || !ndf_io_oe) hold_viol++;
    end
    if (!ndf_r_b_n && !cfg_rb_forever && c2_cyc != cyc) begin
      if (rb_cnt == 0) begin
        ndf_r_b_n = 1'b1;
        rise_cyc  = cyc;
      end else begin
        rb_cnt--;
      end
    end
    if (p_re_n && !ndf_re_n) re_pulses++;
    if (!p_re_n && ndf_re_n) rd_idx++;
    ndf_io_i = (rd_idx < 4096) ? mdata[rd_idx] : 8'hFF;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (timeout) begin to_cnt++; to_cyc = cyc; end
    if (dout_valid) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    case (cfg_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = (first_valid_cyc >= 0 && cyc >= first_valid_cyc + 20);
    endcase
    if (cfg_mode == 2 && dout_ready && !p_ready && re_at_ready < 0) re_at_ready = re_pulses;
    if (dout_valid && dout_ready) rx_q.push_back(dout_data);
    p_busy = busy; p_we_n = ndf_we_n; p_re_n = ndf_re_n;
    p_cle = ndf_cle; p_ale = ndf_ale; p_io = ndf_io_o; p_ready = dout_ready;
  end

  typedef struct {
    logic [15:0] col;
    logic [23:0] row;
    int          len;
    int          rb_cycles;
    bit          rb_forever;
    int          ready_mode;
    bit          dbl_start;
    bit          pattern;
    int          exp_done;
    int          exp_timeout;
    int          exp_nbytes;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int exp_wr[$];
    int errs;
    int budget;
    int b;
    cfg_rb_cycles  = v.rb_cycles;
    cfg_rb_forever = v.rb_forever;
    cfg_mode       = v.ready_mode;
    for (int i = 0; i < 4096; i++) mdata[i] = v.pattern ? 8'(8'hA0 + i) : 8'($urandom);
    exp_wr.push_back((1 << 9) | 8'h00);
    for (int i = 0; i < ADDR_CYCLES; i++) begin
      b = (i < 2) ? ((int'(v.col) >> (8 * i)) & 255) : ((int'(v.row) >> (8 * (i - 2))) & 255);
      exp_wr.push_back((1 << 8) | b);
    end
    exp_wr.push_back((1 << 9) | 8'h30);

    @(negedge clk10); #5;
    col = v.col; row = v.row; len = LEN_W'(v.len); start = 1'b1;
    @(negedge clk10); #5;
    start = 1'b0;
    check("first_bus_cycle", {busy, ndf_ce_n, ndf_cle, ndf_we_n, ndf_io_o}, {4'b1010, 8'h00});
    if (v.dbl_start) begin
      for (int k = 0; k < 50 && wr_q.size() < 2; k++) begin @(negedge clk10); #1; end
      #4;
      col = ~v.col; row = ~v.row; len = LEN_W'(7); start = 1'b1;
      @(negedge clk10); #5;
      start = 1'b0;
    end
    budget = 22000 + 12 * v.len;
    for (int k = 0; k < budget && (done_cnt + to_cnt) == 0; k++) begin @(negedge clk10); #1; end
    repeat (4) @(negedge clk10);
    #1;

    check("bus_writes", wr_q.size(), exp_wr.size());
    errs = 0;
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) if (wr_q[i] != exp_wr[i]) errs++;
    check("bus_bytes_bad", errs, 0);
    check("we_low_runs", we_viol, 0);
    check("write_hold", hold_viol, 0);
    check("done_pulses", done_cnt, v.exp_done);
    check("timeout_pulses", to_cnt, v.exp_timeout);
    check("rx_count", rx_q.size(), v.exp_nbytes);
    errs = 0;
    for (int i = 0; i < rx_q.size() && i < 4096; i++) if (rx_q[i] != mdata[i]) errs++;
    check("rx_data_bad", errs, 0);
    check("re_pulses", re_pulses, v.exp_nbytes);
    check("idle_after", {busy, ndf_ce_n, ndf_io_oe, dout_valid}, 4'b0100);
    if (v.len == 0 && v.exp_done == 1) check("len0_done_latency", done_cyc - rise_cyc, 3);
    if (v.exp_timeout == 1) begin
      check("timeout_latency", to_cyc - c2_cyc, 2 + TWB_CYCLES + TIMEOUT_CYCLES);
      check("timeout_no_valid", valid_cycles, 0);
    end
    if (v.ready_mode == 2) check("re_before_ready", re_at_ready, 1);
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    vecs[0] = '{16'h0004, 24'h012345, 4,    50, 1'b0, 0, 1'b0, 1'b1, 1, 0, 4};
    vecs[1] = '{16'h0100, 24'h000010, 3,    30, 1'b0, 2, 1'b0, 1'b0, 1, 0, 3};
    vecs[2] = '{16'h0000, 24'h000001, 0,    10, 1'b0, 0, 1'b0, 1'b0, 1, 0, 0};
    vecs[3] = '{16'h1234, 24'hABCDEF, 2,    20, 1'b0, 0, 1'b1, 1'b0, 1, 0, 2};
    vecs[4] = '{16'hFFFF, 24'h800000, 1,    15, 1'b0, 1, 1'b0, 1'b0, 1, 0, 1};
    vecs[5] = '{16'h0000, 24'hFFFFFF, 4096, 25, 1'b0, 0, 1'b0, 1'b0, 1, 0, 4096};
    vecs[6] = '{16'h0042, 24'h00AA55, 8,    0,  1'b1, 0, 1'b0, 1'b0, 0, 1, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk10);
    #1;
    check("reset_state",
          {ndf_ce_n, ndf_cle, ndf_ale, ndf_we_n, ndf_re_n, ndf_wp_n, ndf_io_oe, ndf_io_o,
           busy, done, timeout, dout_valid},
          {7'b1001100, 8'h00, 4'b0000});
    #4;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.col = 16'($urandom); rv.row = 24'($urandom);
      rv.len = $urandom_range(0, 40); rv.rb_cycles = $urandom_range(5, 60);
      rv.rb_forever = 1'b0; rv.ready_mode = 1; rv.dbl_start = 1'b0; rv.pattern = 1'b0;
      rv.exp_done = 1; rv.exp_timeout = 0; rv.exp_nbytes = rv.len;
      run_vec(rv);
    end

    // Reset during RD_L2 of the second byte.
    cfg_rb_cycles = 20; cfg_rb_forever = 1'b0; cfg_mode = 0;
    for (int i = 0; i < 4096; i++) mdata[i] = 8'($urandom);
    @(negedge clk10); #5;
    col = 16'h0010; row = 24'h000123; len = LEN_W'(4); start = 1'b1;
    @(negedge clk10); #5;
    start = 1'b0;
    for (int k = 0; k < 2000 && !(re_pulses == 2 && !ndf_re_n); k++) begin @(negedge clk10); #1; end
    @(negedge clk10); #5;
    check("rst_setup_in_read", {re_pulses == 2, ndf_re_n}, 2'b10);
    rst = 1'b1;
    @(negedge clk10); #5;
    check("rst_mid_read", {ndf_ce_n, ndf_re_n, ndf_io_oe, dout_valid, busy}, 5'b11000);
    rst = 1'b0;
    rv = '{16'h0200, 24'h000321, 5, 12, 1'b0, 0, 1'b0, 1'b0, 1, 0, 5};
    run_vec(rv);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ndf_page_reader.md
Name: ndf_page_reader

Overview:
- Sequences one NAND page read on the ndf_* bus, replacing the character-at-a-time serial poking of the flash pins.
- Issues command 00h, ADDR_CYCLES address bytes and command 30h, then waits for R/B# to return high.
- Clocks out LEN bytes using RE# strobes and presents them on a valid/ready byte stream for the USB EP1 / serial consumers.
- Sits between the host-side command decoder and the flash pins; all flash timing is derived from clk10, where one cycle is 100 ns and exceeds every NAND minimum.

Parameters:
- ADDR_CYCLES, 5: address bytes issued; column is 2 bytes, row is ADDR_CYCLES-2 bytes, each sent LSB first.
- LEN_W, 13: width of the len port; maximum len is 4096.
- TWB_CYCLES, 2: cycles idled after the 30h WE# rising edge before R/B# is sampled.
- TIMEOUT_CYCLES, 20000: maximum cycles spent waiting for R/B# high (2 ms).

Ports:
- clk10  in  1  system clock, 10 MHz.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only while busy=0.
- col  in  16  column address.
- row  in  24  row address; bytes above ADDR_CYCLES-2 are ignored.
- len  in  LEN_W  bytes to read; 0 means no data phase.
- busy  out  1  high from the cycle after an accepted start until done/timeout.
- done  out  1  one-cycle pulse; operation completed.
- timeout  out  1  one-cycle pulse; R/B# wait expired; the operation is aborted.
- ndf_r_b_n  in  1  asynchronous open-drain ready/busy.
- ndf_ce_n, ndf_cle, ndf_ale, ndf_we_n, ndf_re_n, ndf_wp_n  out  1 each  flash control.
- ndf_io_o  out  8  flash write data.
- ndf_io_oe  out  1  drive enable; the top level tristates ndf_io when low.
- ndf_io_i  in  8  flash read data.
- dout_data  out  8  read byte.
- dout_valid  out  1  dout_data is valid.
- dout_ready  in  1  consumer accepts a byte when valid and ready are both high.

Behaviour:
- All outputs are registered. Reset/idle values:
  - ce_n=1, cle=0, ale=0, we_n=1, re_n=1, wp_n=0 (permanently; the block is read-only).
  - io_oe=0, io_o=00h, busy=0, done=0, timeout=0, dout_valid=0.
- ndf_r_b_n passes through a 2-flop synchronizer before use, giving 2 cycles of sampling latency.
- Start accepted at cycle N:
  - inputs are latched;
  - busy=1 and ce_n=0 in cycle N+1;
  - the first CLE/WE# low cycle is N+1.
- Write cycle (command or address), two cycles:
  - S: we_n=0, io_oe=1, io_o=byte, cle or ale=1.
  - H: we_n=1, same byte, cle/ale held; this gives the data hold time across the WE# rising edge.
- FSM sequence:
  - IDLE -> CMD1_S/H (00h) -> ADDR_S/H, looped ADDR_CYCLES times, byte order col[7:0], col[15:8], row[7:0], row[15:8], row[23:16].
  - -> CMD2_S/H (30h) -> TWB (TWB_CYCLES cycles) -> WAIT_RB.
- WAIT_RB:
  - on synchronized R/B#=1, go to RD_L1 if len≠0, else to DONE;
  - a counter runs from 0; reaching TIMEOUT_CYCLES-1 goes to ERR.
- Read cycle:
  - RD_L1: re_n=0.
  - RD_L2: re_n=0; ndf_io_i is captured into dout_data at the end of RD_L2, and dout_valid=1 from the next cycle.
  - RD_H: re_n=1 for at least 1 cycle.
  - The byte counter increments on capture.
  - RD_H waits while dout_valid=1 and dout_ready=0. No RE# pulse is issued while the holding register is full, so there is no overflow and no dropped byte.
  - Peak rate is 1 byte per 3 cycles; the transfer ends after len captures, once the final byte has been accepted.
- DONE: one cycle; done=1, ce_n=1, busy=0 next cycle.
- ERR: one cycle; timeout=1, ce_n=1; no bytes are emitted.
- start while busy=1 is ignored and has no side effects. Input changes mid-operation are ignored because inputs are latched.
- rst mid-operation: the next cycle all outputs take their reset values (ce_n=1, io_oe=0), any pending dout_valid is dropped, and the FSM goes to IDLE.
- dout_valid and dout_ready together with a capture in the same cycle: the new byte replaces the accepted one and valid stays 1.
- Byte counter is LEN_W bits and compares for equality with len; no wrap occurs for len ≤ 4096.

Decomposition:
- Package ndf_pkg holds:
  - constants NDF_CMD_READ1=8'h00, NDF_CMD_READ2=8'h30;
  - FSM state encoding, 4 bits: IDLE, CMD1_S, CMD1_H, ADDR_S, ADDR_H, CMD2_S, CMD2_H, TWB, WAIT_RB, RD_L1, RD_L2, RD_H, DONE, ERR.
- One sub-module, ndf_rb_sync: 2-flop synchronizer for R/B#, resetting to 1.

Test Plan:
- Basic read: start with col=0004h, row=012345h, len=4; model R/B# low for 50 cycles; model data A0h..A3h.
  - Bus sequence: CLE 00h; ALE 04h, 00h, 45h, 23h, 01h; CLE 30h.
  - dout A0h, A1h, A2h, A3h, then done; WE# is low for exactly 1 cycle per byte.
- Backpressure: len=3, dout_ready held low for 20 cycles after the first byte.
  - Exactly 1 RE# pulse occurs until ready rises; all 3 bytes arrive in order.
- Timeout: R/B# held low forever.
  - timeout pulses TIMEOUT_CYCLES cycles after entering WAIT_RB; done never asserts; ce_n=1 afterwards; no dout_valid.
- len=0: done follows R/B# high (after synchronizer latency) with no RE# pulses.
- Start while busy: second start during ADDR ignored; only one 00h/30h pair appears on the bus.
- Reset mid-read: rst asserted during RD_L2 of byte 2.
  - Next cycle ce_n=1, re_n=1, io_oe=0, dout_valid=0, busy=0; a subsequent start runs normally.
